if_sequencer: RTL and testbench

IF_SEQUENCER -- requirements
Module: if_sequencer

---
 rtl/mips_pkg.sv | 34 +++
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/if_sequencer.sv | 124 ++++++++++++
 tb/tb_if_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the instruction-fetch sequencer.
//   WORD_W        : datapath / address width (word-index addressing)
//   FIFO_DEPTH    : entries in the fetch FIFO between sequencer and decode
//   seq_state_t   : sequencer FSM states
//   fetch_entry_t : one fetched instruction tagged with its word index
//   in_program()  : true when a word index lies inside the program image
// ---------------------------------------------------------------------------
package mips_pkg;

   localparam int WORD_W     = 32;
   localparam int FIFO_DEPTH = 2;
   localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
   localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_t;

   typedef struct packed {
      logic [WORD_W-1:0] pc;
      logic [WORD_W-1:0] instr;
   } fetch_entry_t;

   // Word indices at or beyond the program length mark end-of-program.
   function automatic logic in_program(input logic [WORD_W-1:0] idx,
                                       input int unsigned       len);
      return idx < WORD_W'(len);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO holding {pc, instr} pairs between the fetch
// sequencer and decode. Flush discards every entry in one cycle and wins
// over push/pop. A push into a full FIFO is accepted only when a pop
// happens in the same cycle, so a full FIFO can stream without a bubble.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : drop all entries
//   push, din  : write request and entry
//   pop        : read request (ignored when empty)
//   dout       : head entry (zero after reset)
//   full/empty : occupancy flags
// ---------------------------------------------------------------------------
module fetch_fifo
   import mips_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  fetch_entry_t din,
   output fetch_entry_t dout,
   output logic         full,
   output logic         empty
);

   fetch_entry_t            mem [FIFO_DEPTH];
   logic [FIFO_PTR_W-1:0]   rd_ptr;
   logic [FIFO_PTR_W-1:0]   wr_ptr;
   logic [FIFO_CNT_W-1:0]   count;
   logic                    do_push;
   logic                    do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FIFO_CNT_W'(FIFO_DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally because FIFO_DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: storage is reset because the head entry is visible on the
         // outputs and must read as zero after reset; a deeper FIFO whose
         // contents never reach a port would leave its array unreset.
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + FIFO_PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + FIFO_PTR_W'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + FIFO_CNT_W'(1);
            2'b01:   count <= count - FIFO_CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/if_sequencer.sv
// ---------------------------------------------------------------------------
// if_sequencer
// Instruction-fetch sequencer. After start it walks a word-index PC from
// RESET_PC, reads the combinational instruction memory at imem_adr = pc and
// queues {pc, instr} into a 2-entry FIFO that feeds decode through a
// valid/ready handshake. Fetching stops (DONE) once pc reaches PROG_LEN; the
// FIFO still drains. A redirect flushes the FIFO and reloads the PC, and
// outranks every other input.
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : one-cycle pulse, IDLE -> RUN
//   imem_adr         : word index presented to instruction memory
//   imem_dout        : instruction word for imem_adr (same cycle)
//   redirect_valid   : taken branch/jump this cycle
//   redirect_pc      : word-index target of the redirect
//   out_valid        : out_instr/out_pc hold a fetched instruction
//   out_ready        : decode accepts the head instruction
//   out_instr/out_pc : head instruction and its word index
//   done             : sequencer is in DONE
// ---------------------------------------------------------------------------
module if_sequencer
   import mips_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = '0,
   parameter int unsigned       PROG_LEN = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [WORD_W-1:0] imem_adr,
   input  logic [WORD_W-1:0] imem_dout,
   input  logic              redirect_valid,
   input  logic [WORD_W-1:0] redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_instr,
   output logic [WORD_W-1:0] out_pc,
   output logic              done
);

   seq_state_t        state;
   logic [WORD_W-1:0] pc;
   logic              done_q;

   logic              fifo_full;
   logic              fifo_empty;
   logic              pop;
   logic              push;
   fetch_entry_t      push_entry;
   fetch_entry_t      head_entry;

   assign imem_adr  = pc;
   assign out_valid = !fifo_empty;
   assign out_instr = head_entry.instr;
   assign out_pc    = head_entry.pc;
   assign done      = done_q;

   assign pop = out_valid && out_ready;

   // A push rides on a same-cycle pop when the FIFO is full. It is gated by
   // the PC being inside the program so the RUN->DONE decision below sees
   // "no push" exactly when the end of the program is reached.
   assign push = (state == ST_RUN) && !redirect_valid
                 && in_program(pc, PROG_LEN)
                 && (!fifo_full || pop);

   assign push_entry.pc    = pc;
   assign push_entry.instr = imem_dout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         pc     <= RESET_PC;
         done_q <= 1'b0;
      end else if (redirect_valid) begin
         // NOTE: non-blocking assignments throughout, so every branch reads
         // the pre-edge values of state and pc regardless of statement order.
         pc <= redirect_pc;
         if (in_program(redirect_pc, PROG_LEN)) begin
            state  <= ST_RUN;
            done_q <= 1'b0;
         end else begin
            state  <= ST_DONE;
            done_q <= 1'b1;
         end
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_RUN;
                  pc    <= RESET_PC;
               end
            end
            ST_RUN: begin
               if (push) begin
                  pc <= pc + WORD_W'(1);
               end else if (!in_program(pc, PROG_LEN)) begin
                  state  <= ST_DONE;
                  done_q <= 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_DONE;
            end
            default: begin
               state  <= ST_IDLE;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   fetch_fifo u_fetch_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect_valid),
      .push  (push),
      .pop   (pop),
      .din   (push_entry),
      .dout  (head_entry),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_if_sequencer.sv
// ---------------------------------------------------------------------------
// tb_if_sequencer
// Directed bench for if_sequencer. A table of per-cycle vectors gives the
// inputs applied during a cycle and the outputs expected to be visible in
// that same cycle (before its rising edge); hand-written sequences cover a
// full free run to end-of-program and an asynchronous reset mid-run.
// Instruction memory is modelled combinationally by imem_word().
// ---------------------------------------------------------------------------
module tb_if_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] imem_adr;
   logic [31:0] imem_dout;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        done;

   int n_checks = 0;
   int n_errors = 0;

   function automatic logic [31:0] imem_word(input logic [31:0] a);
      return 32'hA1290000 + a * 32'h00210001;
   endfunction

   assign imem_dout = imem_word(imem_adr);

   if_sequencer #(
      .RESET_PC (32'd0),
      .PROG_LEN (12)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .imem_adr       (imem_adr),
      .imem_dout      (imem_dout),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .done           (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      bit          rst;
      bit          start;
      bit          ready;
      bit          rv;
      logic [31:0] rpc;
      bit          e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      bit          e_done;
      logic [31:0] e_adr;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(bit rst, bit st, bit rdy, bit rv,
                               logic [31:0] rpc, bit ev, logic [31:0] epc,
                               bit ed, logic [31:0] eadr);
      vec_t v;
      v.rst     = rst;
      v.start   = st;
      v.ready   = rdy;
      v.rv      = rv;
      v.rpc     = rpc;
      v.e_valid = ev;
      v.e_pc    = epc;
      v.e_instr = imem_word(epc);
      v.e_done  = ed;
      v.e_adr   = eadr;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      start          = 1'b0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
   endtask

   task automatic do_reset();
      drive_idle();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      vec_t v;
      int   pops;
      logic [31:0] last_pc;
      bit   seen_done;

      rst_n = 1'b1;
      drive_idle();

      // ---------------- reset state ----------------
      do_reset();
      #1;
      check("reset out_valid", {31'd0, out_valid}, 32'd0);
      check("reset done",      {31'd0, done},      32'd0);
      check("reset imem_adr",  imem_adr,           32'd0);
      check("reset out_pc",    out_pc,             32'd0);
      check("reset out_instr", out_instr,          32'd0);

      // ---------------- vector table ----------------
      // rst st rdy rv rpc | ev epc ed adr
      // basic streaming, start ignored while running
      vq.push_back(mk(1, 1, 1, 0, 0,  0, 0,  0, 0));
      vq.push_back(mk(0, 0, 1, 0, 0,  0, 0,  0, 0));
      vq.push_back(mk(0, 0, 1, 0, 0,  1, 0,  0, 1));
      vq.push_back(mk(0, 1, 1, 0, 0,  1, 1,  0, 2));
      vq.push_back(mk(0, 0, 1, 0, 0,  1, 2,  0, 3));
      vq.push_back(mk(0, 0, 1, 0, 0,  1, 3,  0, 4));
      vq[2].e_instr = 32'hA1290000;
      vq[3].e_instr = 32'hA14A0001;
      // backpressure: out_ready low 5 cycles after start
      vq.push_back(mk(1, 1, 0, 0, 0,  0, 0,  0, 0));
      vq.push_back(mk(0, 0, 0, 0, 0,  0, 0,  0, 0));
      vq.push_back(mk(0, 0, 0, 0, 0,  1, 0,  0, 1));
      vq.push_back(mk(0, 0, 0, 0, 0,  1, 0,  0, 2));
      vq.push_back(mk(0, 0, 0, 0, 0,  1, 0,  0, 2));
      vq.push_back(mk(0, 0, 1, 0, 0,  1, 0,  0, 2));
      vq.push_back(mk(0, 0, 1, 0, 0,  1, 1,  0, 3));
      vq.push_back(mk(0, 0, 0, 0, 0,  1, 2,  0, 4));
      // redirect to 9 with two entries queued, run into DONE
      vq.push_back(mk(0, 0, 0, 1, 9,  1, 2,  0, 4));
      vq.push_back(mk(0, 0, 1, 0, 0,  0, 0,  0, 9));
      vq.push_back(mk(0, 0, 1, 0, 0,  1, 9,  0, 10));
      vq.push_back(mk(0, 0, 1, 0, 0,  1, 10, 0, 11));
      vq.push_back(mk(0, 0, 1, 0, 0,  1, 11, 0, 12));
      vq.push_back(mk(0, 0, 1, 0, 0,  0, 0,  1, 12));
      vq.push_back(mk(0, 0, 1, 0, 0,  0, 0,  1, 12));
      // redirect to 4 from DONE resumes fetching
      vq.push_back(mk(0, 0, 1, 1, 4,  0, 0,  1, 12));
      vq.push_back(mk(0, 0, 0, 0, 0,  0, 0,  0, 4));
      vq.push_back(mk(0, 0, 1, 0, 0,  1, 4,  0, 5));
      // redirect to 11 inside RUN, reach DONE again
      vq.push_back(mk(0, 0, 1, 1, 11, 1, 5,  0, 6));
      vq.push_back(mk(0, 0, 1, 0, 0,  0, 0,  0, 11));
      vq.push_back(mk(0, 0, 1, 0, 0,  1, 11, 0, 12));
      vq.push_back(mk(0, 0, 1, 0, 0,  0, 0,  1, 12));
      // redirect to 20 from DONE stays in DONE
      vq.push_back(mk(0, 0, 1, 1, 20, 0, 0,  1, 12));
      vq.push_back(mk(0, 0, 1, 0, 0,  0, 0,  1, 20));
      vq.push_back(mk(0, 0, 1, 0, 0,  0, 0,  1, 20));

      foreach (vq[i]) begin
         v = vq[i];
         if (v.rst) do_reset();
         @(negedge clk);
         start          = v.start;
         out_ready      = v.ready;
         redirect_valid = v.rv;
         redirect_pc    = v.rpc;
         #1;
         check($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, {31'd0, v.e_valid});
         check($sformatf("vec%0d done", i),      {31'd0, done},      {31'd0, v.e_done});
         check($sformatf("vec%0d imem_adr", i),  imem_adr,           v.e_adr);
         if (v.e_valid) begin
            check($sformatf("vec%0d out_pc", i),    out_pc,    v.e_pc);
            check($sformatf("vec%0d out_instr", i), out_instr, v.e_instr);
         end
      end

      // ---------------- free run to end of program ----------------
      do_reset();
      @(negedge clk);
      start     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      pops      = 0;
      last_pc   = 32'hFFFF_FFFF;
      seen_done = 1'b0;
      for (int c = 0; c < 40 && !seen_done; c++) begin
         #1;
         if (done) begin
            seen_done = 1'b1;
         end else begin
            if (out_valid) begin
               check($sformatf("run out_pc #%0d", pops), out_pc, pops);
               last_pc = out_pc;
               pops++;
            end
            @(negedge clk);
         end
      end
      check("run reached done", {31'd0, seen_done}, 32'd1);
      check("run pop count",    pops,               32'd12);
      check("run last out_pc",  last_pc,            32'd11);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         check($sformatf("run idle valid %0d", c), {31'd0, out_valid}, 32'd0);
         check($sformatf("run idle adr %0d", c),   imem_adr,           32'd12);
      end

      // ---------------- asynchronous reset mid-run ----------------
      do_reset();
      @(negedge clk);
      start     = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("pre-reset out_valid", {31'd0, out_valid}, 32'd1);
      check("pre-reset imem_adr",  imem_adr,           32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("async rst out_valid", {31'd0, out_valid}, 32'd0);
      check("async rst done",      {31'd0, done},      32'd0);
      check("async rst imem_adr",  imem_adr,           32'd0);
      check("async rst out_pc",    out_pc,             32'd0);
      check("async rst out_instr", out_instr,          32'd0);
      repeat (2) @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         check($sformatf("post-rst idle valid %0d", c), {31'd0, out_valid}, 32'd0);
         check($sformatf("post-rst idle adr %0d", c),   imem_adr,           32'd0);
      end
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #1;
      check("restart out_valid", {31'd0, out_valid}, 32'd1);
      check("restart out_pc",    out_pc,             32'd0);
      check("restart out_instr", out_instr,          32'hA1290000);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
